// File: rtl/freq_counter_pkg.sv
// Shared definitions for the BCD frequency counter: edge-mode encodings,
// the conversion state type and the digit-count helper.
package freq_counter_pkg;

    // Edge selection on the mode input; the remaining code is treated as rising.
    localparam logic [1:0] MODE_RISE = 2'd0;
    localparam logic [1:0] MODE_FALL = 2'd1;
    localparam logic [1:0] MODE_BOTH = 2'd2;

    // Sequential binary-to-BCD converter states.
    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    // Largest value representable with the given number of decimal digits.
    function automatic int max_count(input int digits);
        int m;
        m = 1;
        for (int i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter. The first shift step is folded into
// the load, so a start at cycle T gives done at cycle T+IN_BITS; bcd holds
// its value from done until the next start.
module bin2bcd_seq
    import freq_counter_pkg::*;
#(
    parameter int IN_BITS = 10,
    parameter int DIGITS  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_BITS-1:0]  bin,
    output logic [4*DIGITS-1:0] bcd,
    output logic                done
);

    localparam int SR_BITS   = 4 * DIGITS + IN_BITS;
    localparam int STEP_BITS = $clog2(IN_BITS + 1);
    localparam logic [STEP_BITS-1:0] LAST_STEP = STEP_BITS'(IN_BITS - 1);

    conv_state_t          state;
    conv_state_t          state_next;
    logic [SR_BITS-1:0]   sr;
    logic [STEP_BITS-1:0] step_cnt;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift left.
    function automatic logic [SR_BITS-1:0] dabble_step(input logic [SR_BITS-1:0] x);
        logic [SR_BITS-1:0] t;
        t = x;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[IN_BITS+4*d +: 4] >= 4'd5) begin
                t[IN_BITS+4*d +: 4] = t[IN_BITS+4*d +: 4] + 4'd3;
            end
        end
        return {t[SR_BITS-2:0], 1'b0};
    endfunction

    // State register plus shift datapath.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CONV_IDLE;
            sr       <= '0;
            step_cnt <= '0;
        end else begin
            state <= state_next;
            case (state)
                CONV_IDLE: begin
                    if (start) begin
                        sr       <= dabble_step({{(4*DIGITS){1'b0}}, bin});
                        step_cnt <= STEP_BITS'(1);
                    end
                end
                CONV_SHIFT: begin
                    sr       <= dabble_step(sr);
                    step_cnt <= step_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and done decode.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            CONV_IDLE:  if (start) state_next = CONV_SHIFT;
            CONV_SHIFT: if (step_cnt == LAST_STEP) state_next = CONV_DONE;
            CONV_DONE: begin
                done       = 1'b1;
                state_next = CONV_IDLE;
            end
            default:    state_next = CONV_IDLE;
        endcase
    end

    assign bcd = sr[SR_BITS-1 -: 4*DIGITS];

endmodule

// File: rtl/freq_counter_bcd.sv
// Multi-digit frequency counter: counts selected edges of an asynchronous
// input over a programmable gate window, then converts the snapshot to
// packed BCD while the next window is already counting.
module freq_counter_bcd
    import freq_counter_pkg::*;
#(
    parameter int          DIGITS         = 3,
    parameter int          PERIOD_BITS    = 16,
    parameter int unsigned DEFAULT_PERIOD = 1200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   signal,
    input  logic [1:0]             mode,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   period_load,
    output logic [4*DIGITS-1:0]    bcd,
    output logic                   valid,
    output logic                   overflow,
    output logic                   busy
);

    localparam int MAX_COUNT = max_count(DIGITS);
    localparam int CNT_BITS  = $clog2(MAX_COUNT + 1);
    localparam logic [CNT_BITS-1:0]    MAX_CNT      = CNT_BITS'(MAX_COUNT);
    localparam logic [PERIOD_BITS-1:0] MIN_PERIOD   = PERIOD_BITS'(CNT_BITS + 2);
    localparam logic [PERIOD_BITS-1:0] RESET_PERIOD = PERIOD_BITS'(DEFAULT_PERIOD);
    localparam logic [4*DIGITS-1:0]    ALL_NINES    = {DIGITS{4'h9}};

    logic                   sig_meta;
    logic                   sig_sync;
    logic                   sig_prev;
    logic                   rise;
    logic                   fall;
    logic                   edge_hit;
    logic [PERIOD_BITS-1:0] period_shadow;
    logic [PERIOD_BITS-1:0] period_active;
    logic [PERIOD_BITS-1:0] eff_period;
    logic [PERIOD_BITS-1:0] gate_cnt;
    logic                   gate_last;
    logic [CNT_BITS-1:0]    edge_cnt;
    logic                   win_ovf;
    logic [CNT_BITS-1:0]    snap_cnt;
    logic                   snap_ovf;
    logic                   ovf_pend;
    logic [4*DIGITS-1:0]    conv_bcd;
    logic                   conv_done;

    // Two-flop synchroniser plus a delay flop for edge detection.
    // NOTE: no reset here, so a reset can never fabricate an edge from a high input.
    always_ff @(posedge clk) begin
        sig_meta <= signal;
        sig_sync <= sig_meta;
        sig_prev <= sig_sync;
    end

    assign rise = sig_sync & ~sig_prev;
    assign fall = ~sig_sync & sig_prev;

    // Edge selection; the reserved mode code falls back to rising edges.
    always_comb begin
        edge_hit = rise;
        case (mode)
            MODE_RISE: edge_hit = rise;
            MODE_FALL: edge_hit = fall;
            MODE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = rise;
        endcase
    end

    // Shadow takes loads at any time; the active period only changes on a window's first cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_shadow <= RESET_PERIOD;
            period_active <= RESET_PERIOD;
        end else begin
            if (period_load) period_shadow <= period;
            if (gate_cnt == '0) period_active <= period_shadow;
        end
    end

    // Short periods are clamped so each conversion ends before the next snapshot.
    assign eff_period = (period_active < MIN_PERIOD) ? MIN_PERIOD : period_active;
    assign gate_last  = (gate_cnt == eff_period - 1'b1);

    // Gate counter runs 0..P-1.
    always_ff @(posedge clk) begin
        if (reset || gate_last) gate_cnt <= '0;
        else                    gate_cnt <= gate_cnt + 1'b1;
    end

    // Running count including this cycle's edge, saturating at the display limit.
    always_comb begin
        snap_cnt = edge_cnt;
        snap_ovf = win_ovf;
        if (edge_hit) begin
            if (edge_cnt == MAX_CNT) snap_ovf = 1'b1;
            else                     snap_cnt = edge_cnt + 1'b1;
        end
    end

    // Edge counter and sticky overflow restart right after the snapshot cycle.
    always_ff @(posedge clk) begin
        if (reset || gate_last) begin
            edge_cnt <= '0;
            win_ovf  <= 1'b0;
        end else begin
            edge_cnt <= snap_cnt;
            win_ovf  <= snap_ovf;
        end
    end

    // Overflow travels alongside the conversion; busy covers the shift phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
        end else if (gate_last) begin
            ovf_pend <= snap_ovf;
            busy     <= 1'b1;
        end else if (conv_done) begin
            busy     <= 1'b0;
        end
    end

    bin2bcd_seq #(
        .IN_BITS (CNT_BITS),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (gate_last),
        .bin   (snap_cnt),
        .bcd   (conv_bcd),
        .done  (conv_done)
    );

    // Result registers update together with a one-cycle valid strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd      <= '0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= conv_done;
            if (conv_done) begin
                bcd      <= ovf_pend ? ALL_NINES : conv_bcd;
                overflow <= ovf_pend;
            end
        end
    end

endmodule

// File: tb/tb_freq_counter_bcd.sv
// Directed bench for freq_counter_bcd with DIGITS=3 (CNT_BITS=10, latency 11).
// Timing convention: counting posedges after the last edge that samples reset
// high, the window's last cycle follows posedge P-1 and valid follows posedge
// P-1+CNT_BITS+1 = P+CNT_BITS.
module tb_freq_counter_bcd;

    localparam int DIGITS         = 3;
    localparam int PERIOD_BITS    = 16;
    localparam int DEFAULT_PERIOD = 1200;
    localparam int CNT_BITS       = 10;
    localparam int FIRST_VALID    = DEFAULT_PERIOD + CNT_BITS;

    logic                   clk;
    logic                   reset;
    logic                   signal;
    logic [1:0]             mode;
    logic [PERIOD_BITS-1:0] period;
    logic                   period_load;
    logic [4*DIGITS-1:0]    bcd;
    logic                   valid;
    logic                   overflow;
    logic                   busy;

    int checks = 0;
    int passes = 0;

    // Stimulus generator controls: half>0 toggles signal every 'half' clocks,
    // half==0 copies sig_manual onto signal.
    int   half = 8;
    logic sig_manual = 1'b0;

    freq_counter_bcd #(
        .DIGITS         (DIGITS),
        .PERIOD_BITS    (PERIOD_BITS),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .signal      (signal),
        .mode        (mode),
        .period      (period),
        .period_load (period_load),
        .bcd         (bcd),
        .valid       (valid),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input waveform: changes 2 time units after each posedge, asynchronous to sampling.
    initial begin
        int tcnt;
        tcnt   = 0;
        signal = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (half == 0) begin
                signal = sig_manual;
                tcnt   = 0;
            end else begin
                tcnt++;
                if (tcnt >= half) begin
                    signal = ~signal;
                    tcnt   = 0;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic load_period(input int v);
        period      = PERIOD_BITS'(v);
        period_load = 1'b1;
        @(posedge clk);
        #1 period_load = 1'b0;
    endtask

    // Counts posedges until valid is seen (sampled 1 unit after the edge);
    // waited = -1 if the limit expires.
    task automatic wait_valid(input int limit, output int waited, output int busy_cycles);
        waited      = -1;
        busy_cycles = 0;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
            if (valid) begin
                waited = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        half = 8;
        mode = 2'd0;
        do_reset();
        checks++; if (bcd !== 12'h000) $display("FAIL reset_bcd: got %h expected %h", bcd, 12'h000); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        begin
            int seen;
            seen = 0;
            repeat (50) begin
                @(posedge clk);
                #1;
                if (valid || busy) seen++;
            end
            checks++; if (seen !== 0) $display("FAIL reset_quiet: got %0d active cycles expected 0", seen); else passes++;
        end
    endtask

    task automatic test_count_modes();
        int w;
        int b;
        logic [1:0]  mode_list [3];
        logic [11:0] exp_list  [3];
        mode_list = '{2'd2, 2'd1, 2'd3};
        exp_list  = '{12'h150, 12'h075, 12'h075};
        half = 8;
        mode = 2'd0;
        do_reset();
        wait_valid(5000, w, b);
        checks++; if (w !== FIRST_VALID) $display("FAIL rise_first_latency: got %0d expected %0d", w, FIRST_VALID); else passes++;
        checks++; if (bcd !== 12'h075) $display("FAIL rise_w0_bcd: got %h expected %h", bcd, 12'h075); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL rise_w0_ovf: got %b expected 0", overflow); else passes++;
        wait_valid(5000, w, b);
        checks++; if (w !== DEFAULT_PERIOD) $display("FAIL rise_spacing: got %0d expected %0d", w, DEFAULT_PERIOD); else passes++;
        checks++; if (bcd !== 12'h075) $display("FAIL rise_w1_bcd: got %h expected %h", bcd, 12'h075); else passes++;
        for (int i = 0; i < 3; i++) begin
            mode = mode_list[i];
            wait_valid(5000, w, b);   // window straddling the mode change
            wait_valid(5000, w, b);
            checks++; if (bcd !== exp_list[i]) $display("FAIL mode%0d_bcd: got %h expected %h", mode_list[i], bcd, exp_list[i]); else passes++;
        end
    endtask

    task automatic test_overflow();
        int w;
        int b;
        half = 1;
        mode = 2'd0;
        do_reset();
        load_period(4000);
        wait_valid(5000, w, b);
        checks++; if (w !== FIRST_VALID - 1) $display("FAIL ovf_w0_latency: got %0d expected %0d", w, FIRST_VALID - 1); else passes++;
        checks++; if (bcd !== 12'h600) $display("FAIL ovf_w0_bcd: got %h expected %h", bcd, 12'h600); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_w0_flag: got %b expected 0", overflow); else passes++;
        wait_valid(5000, w, b);
        checks++; if (w !== 4000) $display("FAIL ovf_w1_spacing: got %0d expected %0d", w, 4000); else passes++;
        checks++; if (bcd !== 12'h999) $display("FAIL ovf_w1_bcd: got %h expected %h", bcd, 12'h999); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_w1_flag: got %b expected 1", overflow); else passes++;
        load_period(1200);
        wait_valid(5000, w, b);
        checks++; if (w !== 3999) $display("FAIL ovf_w2_spacing: got %0d expected %0d", w, 3999); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_w2_flag: got %b expected 1", overflow); else passes++;
        wait_valid(5000, w, b);
        checks++; if (w !== 1200) $display("FAIL ovf_w3_spacing: got %0d expected %0d", w, 1200); else passes++;
        checks++; if (bcd !== 12'h600) $display("FAIL ovf_w3_bcd: got %h expected %h", bcd, 12'h600); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_w3_flag: got %b expected 0", overflow); else passes++;
    endtask

    // 1998-cycle window holds exactly 999 rises; 2000 cycles gives 1000 and saturates.
    task automatic test_saturation_boundary();
        int w;
        int b;
        half = 1;
        mode = 2'd0;
        do_reset();
        load_period(1998);
        wait_valid(5000, w, b);
        wait_valid(5000, w, b);
        checks++; if (w !== 1998) $display("FAIL sat999_spacing: got %0d expected %0d", w, 1998); else passes++;
        checks++; if (bcd !== 12'h999) $display("FAIL sat999_bcd: got %h expected %h", bcd, 12'h999); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL sat999_flag: got %b expected 0", overflow); else passes++;
        load_period(2000);
        wait_valid(5000, w, b);
        wait_valid(5000, w, b);
        checks++; if (w !== 2000) $display("FAIL sat1000_spacing: got %0d expected %0d", w, 2000); else passes++;
        checks++; if (bcd !== 12'h999) $display("FAIL sat1000_bcd: got %h expected %h", bcd, 12'h999); else passes++;
        checks++; if (overflow !== 1'b1) $display("FAIL sat1000_flag: got %b expected 1", overflow); else passes++;
    endtask

    // Both-edge mode: a rise detected on cycle 1199 (last of window 0) and a
    // fall detected on cycle 1200 (first of window 1). Input changes in cycle
    // j are detected in cycle j+2.
    task automatic test_window_boundary();
        int w;
        int b;
        half       = 0;
        sig_manual = 1'b0;
        mode       = 2'd2;
        repeat (5) @(posedge clk);
        do_reset();
        repeat (1197) @(posedge clk);
        #1 sig_manual = 1'b1;
        @(posedge clk);
        #1 sig_manual = 1'b0;
        wait_valid(5000, w, b);
        checks++; if (w !== FIRST_VALID - 1198) $display("FAIL edge_w0_latency: got %0d expected %0d", w, FIRST_VALID - 1198); else passes++;
        checks++; if (bcd !== 12'h001) $display("FAIL edge_last_cycle_bcd: got %h expected %h", bcd, 12'h001); else passes++;
        wait_valid(5000, w, b);
        checks++; if (bcd !== 12'h001) $display("FAIL edge_first_cycle_bcd: got %h expected %h", bcd, 12'h001); else passes++;
        wait_valid(5000, w, b);
        checks++; if (bcd !== 12'h000) $display("FAIL edge_empty_bcd: got %h expected %h", bcd, 12'h000); else passes++;
    endtask

    // Period 5 clamps to CNT_BITS+2 = 12; busy spans CNT_BITS cycles per window.
    task automatic test_short_period();
        int w;
        int b;
        half = 1;
        mode = 2'd0;
        do_reset();
        load_period(5);
        wait_valid(5000, w, b);
        checks++; if (bcd !== 12'h600) $display("FAIL short_w0_bcd: got %h expected %h", bcd, 12'h600); else passes++;
        for (int i = 0; i < 3; i++) begin
            wait_valid(100, w, b);
            checks++; if (w !== 12) $display("FAIL short_spacing_%0d: got %0d expected %0d", i, w, 12); else passes++;
            checks++; if (bcd !== 12'h006) $display("FAIL short_bcd_%0d: got %h expected %h", i, bcd, 12'h006); else passes++;
            checks++; if (b !== CNT_BITS) $display("FAIL short_busy_len_%0d: got %0d expected %0d", i, b, CNT_BITS); else passes++;
            checks++; if (busy !== 1'b0) $display("FAIL short_busy_at_valid_%0d: got %b expected 0", i, busy); else passes++;
        end
        load_period(0);
        wait_valid(100, w, b);
        checks++; if (w !== 11) $display("FAIL zero_load_spacing: got %0d expected %0d", w, 11); else passes++;
        wait_valid(100, w, b);
        checks++; if (w !== 12) $display("FAIL zero_clamp_spacing: got %0d expected %0d", w, 12); else passes++;
        checks++; if (bcd !== 12'h006) $display("FAIL zero_clamp_bcd: got %h expected %h", bcd, 12'h006); else passes++;
    endtask

    // Runs on from the short-period state, so bcd is non-zero before reset.
    task automatic test_reset_mid_conversion();
        int w;
        int b;
        int found;
        found = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                found = 1;
                break;
            end
        end
        checks++; if (found !== 1) $display("FAIL midrst_busy_seen: got %0d expected 1", found); else passes++;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++; if (bcd !== 12'h000) $display("FAIL midrst_bcd: got %h expected %h", bcd, 12'h000); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", valid); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL midrst_overflow: got %b expected 0", overflow); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else passes++;
        wait_valid(5000, w, b);
        checks++; if (w !== FIRST_VALID) $display("FAIL midrst_next_valid: got %0d expected %0d", w, FIRST_VALID); else passes++;
        checks++; if (bcd !== 12'h600) $display("FAIL midrst_bcd_after: got %h expected %h", bcd, 12'h600); else passes++;
    endtask

    initial begin
        reset       = 1'b1;
        mode        = 2'd0;
        period      = '0;
        period_load = 1'b0;
        test_reset();
        test_count_modes();
        test_overflow();
        test_saturation_boundary();
        test_window_boundary();
        test_short_period();
        test_reset_mid_conversion();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
